// File: rtl/rpn_program_sequencer.sv
// Program sequencer for the RPN stack calculator.
// Fetches 7-bit words {cmd, num} from a synchronous program ROM, hands each non-halt word
// to the calculator over its req/en handshake, and streams out every `eq` result with an ordinal.
// Optional build macro: SEQ_DEPTH_CHECK_EN adds stack-depth tracking and under/overflow faults.
module rpn_program_sequencer #(
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned RES_W       = 3,
  parameter int unsigned TIMEOUT     = 15,
  parameter int unsigned STACK_DEPTH = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [6:0]        rom_data_i,
  input  logic              calc_req_i,
  output logic              calc_en_o,
  output logic [6:0]        calc_variable_o,
  input  logic              calc_valid_i,
  input  logic [9:0]        calc_answer_i,
  output logic              res_valid_o,
  output logic [9:0]        res_data_o,
  output logic [RES_W-1:0]  res_index_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [2:0]        err_code_o
);

  localparam int unsigned TimerW = $clog2(TIMEOUT + 1);
  localparam int unsigned CntW   = RES_W + 1;

  localparam logic [ADDR_W-1:0] AddrMax = '1;
  // One past the last result slot: an eq seen with this count would overflow res_index.
  localparam logic [CntW-1:0]   ResMax  = {1'b1, {RES_W{1'b0}}};
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT - 1);

  localparam logic [2:0] OpRead = 3'd0;
  localparam logic [2:0] OpEq   = 3'd6;
  localparam logic [2:0] OpHalt = 3'd7;

  localparam logic [2:0] ErrNone      = 3'd0;
  localparam logic [2:0] ErrUnderflow = 3'd1;
  localparam logic [2:0] ErrOverflow  = 3'd2;
  localparam logic [2:0] ErrTimeout   = 3'd3;
  localparam logic [2:0] ErrWrap      = 3'd4;
  localparam logic [2:0] ErrResOvf    = 3'd5;

  typedef enum logic [2:0] {
    StIdle, StFetch, StDecode, StIssue, StGap, StWaitEq, StDone, StErr
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [6:0]          word_q, word_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic                res_valid_q, res_valid_d;
  logic [9:0]          res_data_q, res_data_d;
  logic [RES_W-1:0]    res_index_q, res_index_d;
  logic [2:0]          err_code_q, err_code_d;
  logic [2:0]          fault_code;
  logic [2:0]          cmd;

  assign cmd = rom_data_i[6:4];

`ifdef SEQ_DEPTH_CHECK_EN
  localparam int unsigned DepthW = $clog2(STACK_DEPTH + 1);
  localparam logic [DepthW-1:0] DepthMax = DepthW'(STACK_DEPTH);

  logic [DepthW-1:0] depth_q, depth_d;

  // Depth register tracks the calculator stack as words are accepted.
  always_ff @(posedge clk_i) begin
    if (rst_i) depth_q <= '0;
    else       depth_q <= depth_d;
  end
`else
  // Stack depth only matters when depth checking is built in.
  logic unused_stack_depth;
  assign unused_stack_depth = ^STACK_DEPTH;
`endif

  // Fault classification of the word currently on rom_data_i (used in DECODE only).
  always_comb begin
    fault_code = ErrNone;
`ifdef SEQ_DEPTH_CHECK_EN
    if (cmd == OpRead && depth_q == DepthMax) begin
      fault_code = ErrOverflow;
    end else if (cmd != OpRead && cmd != OpEq && cmd != OpHalt && depth_q < DepthW'(2)) begin
      fault_code = ErrUnderflow;
    end else if (cmd == OpEq && depth_q == '0) begin
      fault_code = ErrUnderflow;
    end
`endif
    if (fault_code == ErrNone && cmd == OpEq && cnt_q == ResMax) begin
      fault_code = ErrResOvf;
    end
  end

  // Next-state and datapath updates for the sequencer FSM.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    word_d      = word_q;
    cnt_d       = cnt_q;
    timer_d     = timer_q;
    res_valid_d = 1'b0;
    res_data_d  = res_data_q;
    res_index_d = res_index_q;
    err_code_d  = err_code_q;
`ifdef SEQ_DEPTH_CHECK_EN
    depth_d     = depth_q;
`endif
    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start_i) begin
          state_d     = StFetch;
          addr_d      = '0;
          cnt_d       = '0;
          res_index_d = '0;
          err_code_d  = ErrNone;
`ifdef SEQ_DEPTH_CHECK_EN
          depth_d     = '0;
`endif
        end
      end
      StFetch: state_d = StDecode;
      StDecode: begin
        if (cmd == OpHalt) begin
          state_d = StDone;
        end else if (fault_code != ErrNone) begin
          state_d    = StErr;
          err_code_d = fault_code;
        end else begin
          word_d  = rom_data_i;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (calc_req_i) begin
`ifdef SEQ_DEPTH_CHECK_EN
          if (word_q[6:4] == OpRead)    depth_d = depth_q + DepthW'(1);
          else if (word_q[6:4] != OpEq) depth_d = depth_q - DepthW'(1);
`endif
          if (word_q[6:4] == OpEq) begin
            state_d = StWaitEq;
            timer_d = '0;
          end else begin
            state_d = StGap;
          end
        end
      end
      StGap: begin
        if (addr_q == AddrMax) begin
          state_d    = StErr;
          err_code_d = ErrWrap;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = StFetch;
        end
      end
      StWaitEq: begin
        // A result arriving on the last allowed cycle still wins over the timeout.
        if (calc_valid_i) begin
          res_valid_d = 1'b1;
          res_data_d  = calc_answer_i;
          res_index_d = cnt_q[RES_W-1:0];
          cnt_d       = cnt_q + CntW'(1);
          state_d     = StGap;
        end else if (timer_q == TimerLast) begin
          state_d    = StErr;
          err_code_d = ErrTimeout;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      word_q      <= '0;
      cnt_q       <= '0;
      timer_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_index_q <= '0;
      err_code_q  <= ErrNone;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      word_q      <= word_d;
      cnt_q       <= cnt_d;
      timer_q     <= timer_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_index_q <= res_index_d;
      err_code_q  <= err_code_d;
    end
  end

  // Strobe is gated by rst so a reset landing on an ISSUE cycle issues nothing.
  assign calc_en_o       = (state_q == StIssue) && calc_req_i && !rst_i;
  assign rom_addr_o      = addr_q;
  assign calc_variable_o = word_q;
  assign res_valid_o     = res_valid_q;
  assign res_data_o      = res_data_q;
  assign res_index_o     = res_index_q;
  assign err_code_o      = err_code_q;
  assign busy_o          = state_q inside {StFetch, StDecode, StIssue, StGap, StWaitEq};
  assign done_o          = (state_q == StDone);
  assign err_o           = (state_q == StErr);

endmodule

// File: doc/rpn_program_sequencer.md
Name: rpn_program_sequencer

Overview:
- Sequences the RPN stack calculator datapath from a program ROM: fetches 7-bit instruction words, issues them to the calculator over its req/en handshake, and captures each `eq` result into an indexed result stream.
- Tracks calculator stack depth, flags program faults, and reports busy/done/error status to the host controller.

Parameters:
- ADDR_W, 5, program ROM address width (program up to 2^ADDR_W words)
- RES_W, 3, result index width (up to 2^RES_W results per run)
- TIMEOUT, 15, max cycles waiting for calc_valid after an `eq` issue
- STACK_DEPTH, 5, calculator stack depth used for overflow checking

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse, begins a run at address 0; ignored unless in IDLE, DONE or ERR
- rom_addr  out  ADDR_W  program ROM address
- rom_data  in  7  instruction {cmd[2:0], num[3:0]}, valid one cycle after rom_addr changes
- calc_req  in  1  calculator ready for a word
- calc_en  out  1  word transfer strobe
- calc_variable  out  7  word to calculator
- calc_valid  in  1  calculator result valid
- calc_answer  in  10  calculator top-of-stack
- res_valid  out  1  one-cycle result strobe
- res_data  out  10  captured result
- res_index  out  RES_W  result ordinal, 0-based per run
- busy  out  1  run in progress
- done  out  1  run ended by halt; held until next start or rst
- err  out  1  run aborted; held until next start or rst
- err_code  out  3  1=underflow, 2=overflow, 3=timeout, 4=address wrap, 5=result overflow, 0=none

Behaviour:
- Opcodes: 0 read (push num), 1 lshift, 2 rshift, 3 mul, 4 add, 5 sub (binary, pop2 push1), 6 eq, 7 halt (never sent to calculator).
- Reset (rst sampled high on clk edge): state IDLE; all outputs 0; depth, result count, timer cleared. Reset mid-run aborts immediately; nothing further is issued.
- States:
  - IDLE: on start, rom_addr<=0, clear done/err/err_code/res_index/depth, busy<=1, go FETCH.
  - FETCH: one cycle for ROM latency, then DECODE.
  - DECODE: cmd=7 -> DONE. Otherwise run checks (see Optional Feature): fault -> ERR; else latch word into calc_variable, go ISSUE.
  - ISSUE: calc_en=calc_req (combinational AND of state and calc_req). Transfer completes on the cycle calc_req&&calc_en.
    - On transfer: update depth.
    - eq -> WAIT_EQ with timer cleared.
    - Other ops -> GAP.
  - GAP: calc_en=0 for exactly one cycle. Then increment rom_addr and go FETCH; if rom_addr was 2^ADDR_W-1, go ERR code 4 instead.
  - WAIT_EQ: first cycle with calc_valid=1 pulses res_valid with res_data=calc_answer and res_index=current count.
    - Count increments on that pulse; then GAP.
    - Timer reaching TIMEOUT without calc_valid -> ERR code 3.
    - A 2^RES_W-th plus one eq -> ERR code 5 before issue.
  - DONE: busy=0, done=1. ERR: busy=0, err=1, err_code held. Both return toward FETCH only via start.
- calc_en is never high outside ISSUE; at most one transfer per word; minimum 3 cycles between transfers.
- Depth: read +1, binary op -1, eq 0.
- start while busy: ignored. start coincident with rst: rst wins.

Optional Feature:
- Macro SEQ_DEPTH_CHECK_EN.
- Defined:
  - DECODE faults a binary op with depth<2 (code 1).
  - DECODE faults a read with depth==STACK_DEPTH (code 2).
  - DECODE faults eq with depth==0 (code 1).
- Undefined: no depth register; codes 1/2 never produced; every non-halt word issued.

Test Plan:
- ROM {03,04,40,60,70}, calc_req tied 1, calculator returns 7 -> exactly 4 calc_en pulses with words 03,04,40,60; one res_valid with res_data=7, res_index=0; then done=1, busy=0.
- Same program, calc_req low for 5 cycles during each ISSUE -> calc_en only when calc_req high; same single result 7.
- ROM {03,40,70} with SEQ_DEPTH_CHECK_EN -> one transfer (03), then err=1, err_code=1, add never issued; without macro -> add issued and done=1.
- ROM {60 at addr 0 after 01} with calc_valid held 0 -> err_code=3 exactly TIMEOUT cycles after the eq transfer, busy=0.
- ROM with no halt (all 01 words, checks disabled) -> 32 transfers, then err_code=4.
- rst asserted two cycles into a run, then start -> outputs cleared, run restarts from rom_addr=0, first word reissued.
